// File: rtl/m72_pkg.sv
// Shared types and helpers for the SDRAM port arbiter.
package m72_pkg;

    // Arbiter state: waiting for a request, or one SDRAM access in flight.
    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    // Client id width: readers use 0..7, the loader uses a dedicated id above them.
    localparam int CLIENT_W = 4;
    localparam logic [CLIENT_W-1:0] SDR_CLIENT_LOADER = 4'd8;

    // Next round-robin pointer after granting idx, wrapping modulo n.
    function automatic int rr_wrap_next(input int idx, input int n);
        int nxt;
        if (idx + 1 >= n) begin
            nxt = 0;
        end else begin
            nxt = idx + 1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first pending client at or after the pointer,
// searching upward and wrapping modulo NUM_RD.
module rr_pick #(
    parameter int NUM_RD = 4,
    parameter int IW     = (NUM_RD > 1) ? $clog2(NUM_RD) : 1
) (
    input  logic [NUM_RD-1:0] i_pend,
    input  logic [IW-1:0]     i_ptr,
    output logic              o_valid,
    output logic [IW-1:0]     o_idx
);

    // Scan NUM_RD positions starting at the pointer; the first hit wins.
    always_comb begin
        logic          w_found;
        logic          w_hit;
        logic [IW-1:0] w_idx;
        int            w_cand;
        w_found = 1'b0;
        w_hit   = 1'b0;
        w_idx   = '0;
        w_cand  = 0;
        for (int k = 0; k < NUM_RD; k++) begin
            w_cand  = (int'(i_ptr) + k) % NUM_RD;
            w_hit   = i_pend[IW'(w_cand)] & ~w_found;
            w_idx   = w_hit ? IW'(w_cand) : w_idx;
            w_found = w_found | w_hit;
        end
        o_valid = w_found;
        o_idx   = w_idx;
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares one SDRAM controller port between the ROM loader (writes, absolute
// priority) and NUM_RD read clients served round-robin. All clients use a
// toggle handshake (pending while req != ack); one access is in flight at a time.
module sdram_port_arbiter
    import m72_pkg::*;
#(
    parameter int NUM_RD  = 4,
    parameter int AW      = 24,
    parameter int DW      = 16,
    parameter int TIMEOUT = 1023
) (
    input  logic                 sys_clk,
    input  logic                 reset,
    input  logic                 ld_req,
    output logic                 ld_ack,
    input  logic [AW-1:0]        ld_addr,
    input  logic [DW-1:0]        ld_data,
    input  logic [1:0]           ld_be,
    input  logic [NUM_RD-1:0]    rd_req,
    output logic [NUM_RD-1:0]    rd_ack,
    input  logic [NUM_RD*AW-1:0] rd_addr,
    output logic [NUM_RD*DW-1:0] rd_data,
    output logic [AW-1:0]        sdr_addr,
    output logic [DW-1:0]        sdr_data,
    output logic [1:0]           sdr_be,
    output logic                 sdr_we,
    output logic                 sdr_req,
    input  logic                 sdr_rdy,
    input  logic [DW-1:0]        sdr_q,
    output logic                 timeout_err
);

    localparam int IW = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    arb_state_t           r_state;
    logic [CLIENT_W-1:0]  r_client;
    logic [CW-1:0]        r_cnt;
    logic [IW-1:0]        r_rr_ptr;
    logic                 r_ld_ack;
    logic [NUM_RD-1:0]    r_rd_ack;
    logic [DW-1:0]        r_rd_data [NUM_RD];
    logic [AW-1:0]        r_sdr_addr;
    logic [DW-1:0]        r_sdr_data;
    logic [1:0]           r_sdr_be;
    logic                 r_sdr_we;
    logic                 r_sdr_req;
    logic                 r_timeout_err;

    logic                 w_ld_pend;
    logic [NUM_RD-1:0]    w_rd_pend;
    logic [AW-1:0]        w_rd_addr [NUM_RD];
    logic                 w_pick_valid;
    logic [IW-1:0]        w_pick_idx;
    logic [IW-1:0]        w_grant_idx;
    logic                 w_is_read;
    logic                 w_timed_out;
    logic                 w_done;
    logic [DW-1:0]        w_done_data;

    assign w_ld_pend   = ld_req ^ r_ld_ack;
    assign w_rd_pend   = rd_req ^ r_rd_ack;
    assign w_grant_idx = r_client[IW-1:0];
    assign w_is_read   = (r_client != SDR_CLIENT_LOADER);
    assign w_timed_out = (r_cnt == CW'(TIMEOUT));
    assign w_done      = sdr_rdy | w_timed_out;
    // An aborted read returns all ones so the client sees an obviously bad word.
    assign w_done_data = sdr_rdy ? sdr_q : {DW{1'b1}};

    for (genvar g = 0; g < NUM_RD; g++) begin : g_client
        assign w_rd_addr[g]         = rd_addr[g*AW +: AW];
        assign rd_data[g*DW +: DW]  = r_rd_data[g];
    end

    rr_pick #(
        .NUM_RD (NUM_RD),
        .IW     (IW)
    ) u_rr_pick (
        .i_pend  (w_rd_pend),
        .i_ptr   (r_rr_ptr),
        .o_valid (w_pick_valid),
        .o_idx   (w_pick_idx)
    );

    // Arbiter FSM: grant in IDLE, hold the request in BUSY until rdy or timeout.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_state       <= ARB_IDLE;
            r_client      <= '0;
            r_cnt         <= '0;
            r_rr_ptr      <= '0;
            r_ld_ack      <= 1'b0;
            r_rd_ack      <= '0;
            r_sdr_addr    <= '0;
            r_sdr_data    <= '0;
            r_sdr_be      <= 2'b00;
            r_sdr_we      <= 1'b0;
            r_sdr_req     <= 1'b0;
            r_timeout_err <= 1'b0;
            for (int i = 0; i < NUM_RD; i++) begin
                r_rd_data[i] <= '0;
            end
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    r_cnt <= '0;
                    if (w_ld_pend) begin
                        // Loader wins outright; readers wait out the ROM download.
                        r_client   <= SDR_CLIENT_LOADER;
                        r_sdr_addr <= ld_addr;
                        r_sdr_data <= ld_data;
                        r_sdr_be   <= ld_be;
                        r_sdr_we   <= 1'b1;
                        r_sdr_req  <= 1'b1;
                        r_state    <= ARB_BUSY;
                    end else if (w_pick_valid) begin
                        r_client   <= CLIENT_W'(w_pick_idx);
                        r_sdr_addr <= w_rd_addr[w_pick_idx];
                        r_sdr_be   <= 2'b11;
                        r_sdr_we   <= 1'b0;
                        r_sdr_req  <= 1'b1;
                        r_rr_ptr   <= IW'(rr_wrap_next(int'(w_pick_idx), NUM_RD));
                        r_state    <= ARB_BUSY;
                    end else begin
                        r_sdr_req  <= 1'b0;
                    end
                end
                ARB_BUSY: begin
                    if (w_done) begin
                        r_sdr_req <= 1'b0;
                        r_cnt     <= '0;
                        r_state   <= ARB_IDLE;
                        if (!sdr_rdy) begin
                            r_timeout_err <= 1'b1;
                        end
                        if (w_is_read) begin
                            r_rd_data[w_grant_idx] <= w_done_data;
                            r_rd_ack[w_grant_idx]  <= ~r_rd_ack[w_grant_idx];
                        end else begin
                            r_ld_ack <= ~r_ld_ack;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_state   <= ARB_IDLE;
                    r_sdr_req <= 1'b0;
                end
            endcase
        end
    end

    assign ld_ack      = r_ld_ack;
    assign rd_ack      = r_rd_ack;
    assign sdr_addr    = r_sdr_addr;
    assign sdr_data    = r_sdr_data;
    assign sdr_be      = r_sdr_be;
    assign sdr_we      = r_sdr_we;
    assign sdr_req     = r_sdr_req;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: single read, loader priority,
// round-robin order, holding-register stability, timeout and mid-access reset.
module tb_sdram_port_arbiter;

    localparam int NUM_RD  = 4;
    localparam int AW      = 24;
    localparam int DW      = 16;
    localparam int TIMEOUT = 15;

    logic                 sys_clk = 1'b0;
    logic                 reset;
    logic                 ld_req;
    logic                 ld_ack;
    logic [AW-1:0]        ld_addr;
    logic [DW-1:0]        ld_data;
    logic [1:0]           ld_be;
    logic [NUM_RD-1:0]    rd_req;
    logic [NUM_RD-1:0]    rd_ack;
    logic [NUM_RD*AW-1:0] rd_addr;
    logic [NUM_RD*DW-1:0] rd_data;
    logic [AW-1:0]        sdr_addr;
    logic [DW-1:0]        sdr_data;
    logic [1:0]           sdr_be;
    logic                 sdr_we;
    logic                 sdr_req;
    logic                 sdr_rdy;
    logic [DW-1:0]        sdr_q;
    logic                 timeout_err;

    int                   n_assert = 0;
    int                   n_fail   = 0;
    logic [NUM_RD-1:0]    exp_ack;
    logic [DW-1:0]        exp_data [NUM_RD];

    always #5 sys_clk = ~sys_clk;

    sdram_port_arbiter #(
        .NUM_RD  (NUM_RD),
        .AW      (AW),
        .DW      (DW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .sys_clk     (sys_clk),
        .reset       (reset),
        .ld_req      (ld_req),
        .ld_ack      (ld_ack),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .ld_be       (ld_be),
        .rd_req      (rd_req),
        .rd_ack      (rd_ack),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .sdr_addr    (sdr_addr),
        .sdr_data    (sdr_data),
        .sdr_be      (sdr_be),
        .sdr_we      (sdr_we),
        .sdr_req     (sdr_req),
        .sdr_rdy     (sdr_rdy),
        .sdr_q       (sdr_q),
        .timeout_err (timeout_err)
    );

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] data_of(input int k);
        return rd_data[k*DW +: DW];
    endfunction

    function automatic logic [AW-1:0] addr_of(input int k);
        return rd_addr[k*AW +: AW];
    endfunction

    // Toggle reader k's request; re-toggling while still pending would lose a request.
    task automatic toggle_rd(input int k);
        check($sformatf("no_retoggle_%0d", k), 64'(rd_req[k] ^ rd_ack[k]), 64'd0);
        rd_req[k] = ~rd_req[k];
    endtask

    // Wait (bounded) for the arbiter to raise sdr_req.
    task automatic wait_issue(input string tag);
        int n = 0;
        while (sdr_req !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check($sformatf("%s_issue", tag), 64'(sdr_req), 64'd1);
    endtask

    // Act as the controller for a read of client k: rdy after lat cycles with data q.
    task automatic serve(input int k, input logic [DW-1:0] q, input int lat);
        check($sformatf("grant_addr_%0d", k), 64'(sdr_addr), 64'(addr_of(k)));
        check($sformatf("grant_we_%0d", k), 64'(sdr_we), 64'd0);
        for (int i = 1; i < lat; i++) tick();
        sdr_rdy = 1'b1;
        sdr_q   = q;
        tick();
        sdr_rdy = 1'b0;
        sdr_q   = '0;
        exp_ack[k]  = ~exp_ack[k];
        exp_data[k] = q;
        check($sformatf("rd_ack_after_%0d", k), 64'(rd_ack), 64'(exp_ack));
        check($sformatf("rd_data_%0d", k), 64'(data_of(k)), 64'(q));
        check($sformatf("req_drop_%0d", k), 64'(sdr_req), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        reset   = 1'b1;
        ld_req  = 1'b0;
        ld_addr = '0;
        ld_data = '0;
        ld_be   = 2'b00;
        rd_req  = '0;
        sdr_rdy = 1'b0;
        sdr_q   = '0;
        rd_addr = {24'h0ABCDE, 24'h012345, 24'h001111, 24'h000040};
        exp_ack = '0;
        for (int k = 0; k < NUM_RD; k++) exp_data[k] = '0;
        repeat (3) tick();

        // Reset state
        check("rst_sdr_req", 64'(sdr_req), 64'd0);
        check("rst_sdr_we", 64'(sdr_we), 64'd0);
        check("rst_sdr_be", 64'(sdr_be), 64'd0);
        check("rst_sdr_addr", 64'(sdr_addr), 64'd0);
        check("rst_sdr_data", 64'(sdr_data), 64'd0);
        check("rst_ld_ack", 64'(ld_ack), 64'd0);
        check("rst_rd_ack", 64'(rd_ack), 64'd0);
        check("rst_rd_data", 64'(rd_data), 64'd0);
        check("rst_timeout_err", 64'(timeout_err), 64'd0);
        reset = 1'b0;
        tick();

        // Single read of client 2: one-cycle grant latency
        toggle_rd(2);
        tick();
        check("t1_req", 64'(sdr_req), 64'd1);
        check("t1_addr", 64'(sdr_addr), 64'h012345);
        check("t1_we", 64'(sdr_we), 64'd0);
        check("t1_be", 64'(sdr_be), 64'h3);
        tick();
        check("t1_addr_stable", 64'(sdr_addr), 64'h012345);
        serve(2, 16'hBEEF, 1);
        check("t1_rd0_untouched", 64'(data_of(0)), 64'd0);

        // Loader and reader 0 in the same cycle: loader write first
        tick();
        check("no_retoggle_ld", 64'(ld_req ^ ld_ack), 64'd0);
        ld_addr = 24'h000100;
        ld_data = 16'h00A5;
        ld_be   = 2'b01;
        ld_req  = ~ld_req;
        toggle_rd(0);
        tick();
        check("pr_req", 64'(sdr_req), 64'd1);
        check("pr_we", 64'(sdr_we), 64'd1);
        check("pr_addr", 64'(sdr_addr), 64'h000100);
        check("pr_data", 64'(sdr_data), 64'h00A5);
        check("pr_be", 64'(sdr_be), 64'h1);
        tick();
        sdr_rdy = 1'b1;
        tick();
        sdr_rdy = 1'b0;
        check("pr_ld_ack", 64'(ld_ack), 64'd1);
        check("pr_rd_ack_wait", 64'(rd_ack), 64'(exp_ack));
        check("pr_idle_gap", 64'(sdr_req), 64'd0);
        tick();
        check("pr_rd0_issue", 64'(sdr_req), 64'd1);
        check("pr_rd0_be", 64'(sdr_be), 64'h3);
        serve(0, 16'h0A0A, 1);

        // Reader 3 alone moves the pointer to 0
        toggle_rd(3);
        wait_issue("p3");
        serve(3, 16'h3333, 1);

        // All four pending twice: order 0,1,2,3 each round
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < NUM_RD; k++) toggle_rd(k);
            for (int k = 0; k < NUM_RD; k++) begin
                wait_issue($sformatf("rr%0d_%0d", r, k));
                serve(k, 16'hA000 + 16'(r * 16 + k), 3);
            end
        end

        // Reader 1 alone puts the pointer at 2; then 1 and 3 pending -> order 3,1
        toggle_rd(1);
        wait_issue("p1");
        serve(1, 16'h1234, 1);
        toggle_rd(1);
        toggle_rd(3);
        wait_issue("rr31_a");
        serve(3, 16'hC003, 3);
        wait_issue("rr31_b");
        serve(1, 16'hC001, 3);

        // Stability: reader 0 holds 16'h1111 while 50 other reads complete
        toggle_rd(0);
        wait_issue("st0");
        serve(0, 16'h1111, 2);
        for (int i = 0; i < 50; i++) begin
            toggle_rd(1 + (i % 3));
            wait_issue("st");
            serve(1 + (i % 3), 16'h2000 + 16'(i), 1 + (i % 3));
        end
        check("st_rd0_hold", 64'(data_of(0)), 64'h1111);
        for (int k = 1; k < NUM_RD; k++) begin
            check($sformatf("st_final_%0d", k), 64'(data_of(k)), 64'(exp_data[k]));
        end

        // Timeout on reader 1: controller never answers
        check("to_err_before", 64'(timeout_err), 64'd0);
        toggle_rd(1);
        wait_issue("to");
        n = 0;
        while (rd_ack[1] === exp_ack[1] && n < 100) begin
            tick();
            n++;
        end
        exp_ack[1] = ~exp_ack[1];
        check("to_ack", 64'(rd_ack), 64'(exp_ack));
        check("to_data", 64'(data_of(1)), 64'hFFFF);
        check("to_err", 64'(timeout_err), 64'd1);
        check("to_req_drop", 64'(sdr_req), 64'd0);
        check("to_window", 64'(n >= TIMEOUT && n <= TIMEOUT + 1), 64'd1);
        check("to_rd0_hold", 64'(data_of(0)), 64'h1111);
        toggle_rd(2);
        wait_issue("to_next");
        serve(2, 16'h5A5A, 2);
        repeat (3) tick();
        check("to_err_sticky", 64'(timeout_err), 64'd1);

        // Reset in the middle of an access
        toggle_rd(3);
        wait_issue("mr");
        tick();
        check("mr_busy", 64'(sdr_req), 64'd1);
        reset  = 1'b1;
        rd_req = '0;
        ld_req = 1'b0;
        tick();
        check("mr_req", 64'(sdr_req), 64'd0);
        check("mr_rd_ack", 64'(rd_ack), 64'd0);
        check("mr_ld_ack", 64'(ld_ack), 64'd0);
        check("mr_err", 64'(timeout_err), 64'd0);
        reset   = 1'b0;
        exp_ack = '0;
        repeat (2) tick();
        sdr_rdy = 1'b1;
        sdr_q   = 16'hDEAD;
        tick();
        sdr_rdy = 1'b0;
        sdr_q   = '0;
        check("mr_stray_ack", 64'(rd_ack), 64'd0);
        check("mr_stray_ld", 64'(ld_ack), 64'd0);
        check("mr_stray_data", 64'(rd_data), 64'd0);
        repeat (3) tick();
        check("mr_stray_req", 64'(sdr_req), 64'd0);
        toggle_rd(0);
        tick();
        check("mr_idle_issue", 64'(sdr_req), 64'd1);
        serve(0, 16'h0F0F, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
